// File: rtl/uart_responder_pkg.sv
// Shared types and constants for the UART responder: bus widths, default divider,
// TX/RX state encodings and the bit-timer width helper.
package uart_responder_pkg;

  localparam int unsigned UartByteW      = 8;
  localparam int unsigned DataBusW       = 16;
  localparam int unsigned UartDefaultDiv = 96;

  typedef logic [UartByteW-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxStart = 2'd1,
    TxData  = 2'd2,
    TxStop  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RxIdle  = 2'd0,
    RxStart = 2'd1,
    RxData  = 2'd2,
    RxStop  = 2'd3
  } rx_state_e;

  function automatic int unsigned timer_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period down-counter with a restart input; strobes once at the
// sampling point and once on the last cycle of every bit period.
module uart_bit_timer
  import uart_responder_pkg::*;
#(
  parameter int unsigned CLK_DIV = UartDefaultDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic mid,
  output logic bit_end
);

  localparam int unsigned W = timer_width(CLK_DIV);
  localparam logic [W-1:0] TopCnt = W'(CLK_DIV - 1);
  // One cycle ahead of the true centre: the 2-flop synchroniser delays the line.
  localparam logic [W-1:0] MidCnt = W'(CLK_DIV - CLK_DIV / 2 + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (load || (cnt_q == '0)) begin
      cnt_d = TopCnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= TopCnt;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mid     = (cnt_q == MidCnt);
  assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_responder.sv
// Device-side UART on the CPU rdn/wrn handshake: 8N1 transmitter and receiver.
// Define UART_LOOPBACK_EN to feed the receiver from the internal txd instead of rxd.
module uart_responder
  import uart_responder_pkg::*;
#(
  parameter int unsigned CLK_DIV = UartDefaultDiv
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [DataBusW-1:0] data,
  input  logic                rdn,
  input  logic                wrn,
  output logic                data_ready,
  output logic                tbre,
  output logic                tsre,
  output logic                txd,
  input  logic                rxd,
  output logic                rx_overrun,
  output logic                rx_frame_err
);

  // Synchronisers reset to the idle (high) level so release never looks like an edge.
  logic [1:0] rdn_sync_q, wrn_sync_q, rxd_sync_q;
  logic       rdn_prev_q, wrn_prev_q, rxd_prev_q;
  logic       rx_line;
  logic       rd_rise, wr_rise, wr_low, rx_s, rx_fall;

  logic       txd_q, txd_d;

`ifdef UART_LOOPBACK_EN
  logic rxd_unused;
  assign rxd_unused = rxd;
  assign rx_line    = txd_q;
`else
  assign rx_line = rxd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_sync_q <= 2'b11;
      wrn_sync_q <= 2'b11;
      rxd_sync_q <= 2'b11;
      rdn_prev_q <= 1'b1;
      wrn_prev_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rdn_sync_q <= {rdn_sync_q[0], rdn};
      wrn_sync_q <= {wrn_sync_q[0], wrn};
      rxd_sync_q <= {rxd_sync_q[0], rx_line};
      rdn_prev_q <= rdn_sync_q[1];
      wrn_prev_q <= wrn_sync_q[1];
      rxd_prev_q <= rxd_sync_q[1];
    end
  end

  assign rd_rise = rdn_sync_q[1] & ~rdn_prev_q;
  assign wr_rise = wrn_sync_q[1] & ~wrn_prev_q;
  assign wr_low  = ~wrn_sync_q[1];
  assign rx_s    = rxd_sync_q[1];
  assign rx_fall = ~rx_s & rxd_prev_q;

  // ---------------------------------------------------------------- write / TX
  uart_byte_t wr_latch_q, wr_latch_d;
  uart_byte_t hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  uart_byte_t tx_sh_q, tx_sh_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic       tsre_q, tsre_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic       tx_take, tx_timer_load, tx_end, tx_mid_unused;
  logic [DataBusW-UartByteW-1:0] data_hi_unused;

  assign data_hi_unused = data[DataBusW-1:UartByteW];

  uart_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_tx_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tx_timer_load),
    .mid    (tx_mid_unused),
    .bit_end(tx_end)
  );

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_sh_d       = tx_sh_q;
    tx_bit_d      = tx_bit_q;
    txd_d         = txd_q;
    tsre_d        = tsre_q;
    tx_take       = 1'b0;
    tx_timer_load = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (hold_full_q) begin
          tx_take       = 1'b1;
          tx_timer_load = 1'b1;
          tx_sh_d       = hold_q;
          txd_d         = 1'b0;
          tsre_d        = 1'b0;
          tx_state_d    = TxStart;
        end
      end
      TxStart: begin
        if (tx_end) begin
          txd_d      = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_bit_d   = 3'd0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_end) begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TxStop;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TxStop: begin
        if (tx_end) begin
          if (hold_full_q) begin
            // Timer auto-reloads here, so the next start bit follows with no idle gap.
            tx_take    = 1'b1;
            tx_sh_d    = hold_q;
            txd_d      = 1'b0;
            tx_state_d = TxStart;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // A TX load in the same cycle frees the holding register before the write is judged.
  always_comb begin
    wr_latch_d  = wr_low ? data[UartByteW-1:0] : wr_latch_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~tx_take;
    if (wr_rise && !hold_full_d) begin
      hold_d      = wr_latch_q;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_latch_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_sh_q     <= '0;
      tx_bit_q    <= '0;
      txd_q       <= 1'b1;
      tsre_q      <= 1'b1;
      tx_state_q  <= TxIdle;
    end else begin
      wr_latch_q  <= wr_latch_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_sh_q     <= tx_sh_d;
      tx_bit_q    <= tx_bit_d;
      txd_q       <= txd_d;
      tsre_q      <= tsre_d;
      tx_state_q  <= tx_state_d;
    end
  end

  // ---------------------------------------------------------------- RX / read
  uart_byte_t rx_sh_q, rx_sh_d;
  uart_byte_t rx_buf_q, rx_buf_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic       dr_q, dr_d, ovr_q, ovr_d, ferr_q, ferr_d;
  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_timer_load, rx_mid, rx_end;

  uart_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_rx_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (rx_timer_load),
    .mid    (rx_mid),
    .bit_end(rx_end)
  );

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_sh_d       = rx_sh_q;
    rx_bit_d      = rx_bit_q;
    rx_buf_d      = rx_buf_q;
    dr_d          = dr_q & ~rd_rise;
    ovr_d         = 1'b0;
    ferr_d        = 1'b0;
    rx_timer_load = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_timer_load = 1'b1;
          rx_state_d    = RxStart;
        end
      end
      RxStart: begin
        if (rx_mid && rx_s) begin
          rx_state_d = RxIdle;
        end else if (rx_end) begin
          rx_bit_d   = 3'd0;
          rx_state_d = RxData;
        end
      end
      RxData: begin
        if (rx_mid) begin
          rx_sh_d = {rx_s, rx_sh_q[UartByteW-1:1]};
        end
        if (rx_end) begin
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxStop: begin
        if (rx_mid) begin
          if (rx_s) begin
            rx_buf_d = rx_sh_q;
            dr_d     = 1'b1;
            ovr_d    = dr_q & ~rd_rise;
          end else begin
            ferr_d = 1'b1;
          end
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rx_bit_q   <= '0;
      dr_q       <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rx_state_q <= RxIdle;
    end else begin
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rx_bit_q   <= rx_bit_d;
      dr_q       <= dr_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      rx_state_q <= rx_state_d;
    end
  end

  // Raw rdn gates the bus so read data is valid combinationally.
  assign data = rdn ? {DataBusW{1'bz}} : {{(DataBusW - UartByteW){1'b0}}, rx_buf_q};

  assign data_ready   = dr_q;
  assign tbre         = ~hold_full_q;
  assign tsre         = tsre_q;
  assign txd          = txd_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_responder.sv
// Directed self-checking bench for uart_responder with CLK_DIV=4.
// Define UART_LOOPBACK_EN to swap the external-RX scenarios for the loopback scenario.
module tb_uart_responder;

  localparam int unsigned Div = 4;

  logic        clk, rst, rdn, wrn, rxd;
  logic        data_ready, tbre, tsre, txd, rx_overrun, rx_frame_err;
  wire  [15:0] data;
  logic [15:0] tb_data;
  logic        tb_drv;

  int checks   = 0;
  int failures = 0;

  assign data = tb_drv ? tb_data : 16'hzzzz;

  uart_responder #(
    .CLK_DIV(Div)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .rdn         (rdn),
    .wrn         (wrn),
    .data_ready  (data_ready),
    .tbre        (tbre),
    .tsre        (tsre),
    .txd         (txd),
    .rxd         (rxd),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // txd log, one entry per cycle sampled mid-cycle
  logic cap_on;
  int   cap_idx;
  logic txlog [0:127];
  always @(negedge clk) begin
    if (!cap_on) begin
      cap_idx <= 0;
    end else if (cap_idx < 128) begin
      txlog[cap_idx] <= txd;
      cap_idx        <= cap_idx + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    tb_data = {8'h00, b};
    tb_drv  = 1'b1;
    wrn     = 1'b0;
    tick(4);
    wrn = 1'b1;
    tick(3);
    tb_drv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(Div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(Div);
    end
    rxd = stop;
    tick(Div);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; tb_drv = 1'b0; tb_data = '0; cap_on = 1'b0;
    tick(3);
    checks++;
    if ({tbre, tsre, txd, data_ready, rx_overrun, rx_frame_err} !== 6'b111000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 111000",
               {tbre, tsre, txd, data_ready, rx_overrun, rx_frame_err});
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if ({tbre, tsre, txd, data_ready} !== 4'b1110) begin
      failures++;
      $display("FAIL idle_flags: got %b expected 1110", {tbre, tsre, txd, data_ready});
    end
    rdn = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_rx_buf: got %h expected 0000", data);
    end
    rdn = 1'b1;
    tick(4);
    tb_drv = 1'b1; tb_data = 16'h5AA5;
    #1;
    checks++;
    if (data !== 16'h5AA5) begin
      failures++;
      $display("FAIL idle_bus_float: got %h expected 5aa5", data);
    end
    tb_drv = 1'b0;
    tick(1);
  endtask

  task automatic test_write;
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    tb_data = 16'h0055; tb_drv = 1'b1; wrn = 1'b0;
    tick(4);
    wrn = 1'b1;
    tick(2);
    checks++;
    if (tbre !== 1'b1) begin
      failures++;
      $display("FAIL tbre_early: got %b expected 1", tbre);
    end
    tick(1);
    checks++;
    if (tbre !== 1'b0) begin
      failures++;
      $display("FAIL tbre_fall: got %b expected 0", tbre);
    end
    tb_drv = 1'b0;
    tick(1);
    checks++;
    if ({txd, tbre, tsre} !== 3'b010) begin
      failures++;
      $display("FAIL tx_load: got txd,tbre,tsre=%b expected 010", {txd, tbre, tsre});
    end
    for (int k = 1; k < 10; k++) begin
      tick(Div);
      checks++;
      if (txd !== frame[k]) begin
        failures++;
        $display("FAIL tx55_bit%0d: got %b expected %b", k, txd, frame[k]);
      end
    end
    checks++;
    if (tsre !== 1'b0) begin
      failures++;
      $display("FAIL tsre_stop: got %b expected 0", tsre);
    end
    tick(Div);
    checks++;
    if ({tsre, txd} !== 2'b11) begin
      failures++;
      $display("FAIL tsre_end: got tsre,txd=%b expected 11", {tsre, txd});
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp;
    exp = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    write_byte(8'hA5);
    tick(1);
    cap_on = 1'b1;
    write_byte(8'h3C);
    checks++;
    if (tbre !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: got tbre=%b expected 0", tbre);
    end
    write_byte(8'hFF);
    checks++;
    if (tbre !== 1'b0) begin
      failures++;
      $display("FAIL b2b_third_pending: got tbre=%b expected 0", tbre);
    end
    tick(65);
    checks++;
    if (tsre !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tsre_busy: got %b expected 0", tsre);
    end
    tick(1);
    checks++;
    if ({tsre, tbre} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_done: got tsre,tbre=%b expected 11", {tsre, tbre});
    end
    tick(12);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (txlog[4 * k + 2] !== exp[k]) begin
        failures++;
        $display("FAIL b2b_bit%0d: got %b expected %b", k, txlog[4 * k + 2], exp[k]);
      end
    end
    for (int i = 80; i < 91; i++) begin
      checks++;
      if (txlog[i] !== 1'b1) begin
        failures++;
        $display("FAIL dropped_write_idle%0d: got %b expected 1", i, txlog[i]);
      end
    end
    cap_on = 1'b0;
  endtask

  task automatic test_rx_read;
    send_frame(8'hC3, 1'b1);
    checks++;
    if ({data_ready, rx_overrun, rx_frame_err} !== 3'b100) begin
      failures++;
      $display("FAIL rx_c3_flags: got %b expected 100", {data_ready, rx_overrun, rx_frame_err});
    end
    tick(2);
    rdn = 1'b0;
    #1;
    checks++;
    if (data !== 16'h00C3) begin
      failures++;
      $display("FAIL read_c3: got %h expected 00c3", data);
    end
    tick(4);
    rdn = 1'b1;
    tick(2);
    checks++;
    if (data_ready !== 1'b1) begin
      failures++;
      $display("FAIL dr_hold: got %b expected 1", data_ready);
    end
    tick(1);
    checks++;
    if (data_ready !== 1'b0) begin
      failures++;
      $display("FAIL dr_clear: got %b expected 0", data_ready);
    end
    tb_drv = 1'b1; tb_data = 16'h1200;
    #1;
    checks++;
    if (data !== 16'h1200) begin
      failures++;
      $display("FAIL bus_float_after_read: got %h expected 1200", data);
    end
    tb_drv = 1'b0;
    tick(2);
  endtask

  task automatic test_overrun_frame_err;
    send_frame(8'h11, 1'b1);
    checks++;
    if ({data_ready, rx_overrun} !== 2'b10) begin
      failures++;
      $display("FAIL rx11: got dr,ovr=%b expected 10", {data_ready, rx_overrun});
    end
    send_frame(8'h22, 1'b1);
    checks++;
    if ({data_ready, rx_overrun} !== 2'b11) begin
      failures++;
      $display("FAIL rx22_overrun: got dr,ovr=%b expected 11", {data_ready, rx_overrun});
    end
    tick(1);
    checks++;
    if (rx_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pulse: got %b expected 0", rx_overrun);
    end
    rdn = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0022) begin
      failures++;
      $display("FAIL read_22: got %h expected 0022", data);
    end
    tick(4);
    rdn = 1'b1;
    tick(4);
    send_frame(8'hF0, 1'b0);
    checks++;
    if ({rx_frame_err, data_ready} !== 2'b10) begin
      failures++;
      $display("FAIL frame_err: got ferr,dr=%b expected 10", {rx_frame_err, data_ready});
    end
    tick(1);
    checks++;
    if (rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_pulse: got %b expected 0", rx_frame_err);
    end
    // one-cycle low glitch must not start a frame
    tick(4);
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(50);
    checks++;
    if ({data_ready, rx_frame_err} !== 2'b00) begin
      failures++;
      $display("FAIL glitch: got dr,ferr=%b expected 00", {data_ready, rx_frame_err});
    end
    rdn = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0022) begin
      failures++;
      $display("FAIL rx_buf_kept: got %h expected 0022", data);
    end
    rdn = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid_tx;
    write_byte(8'h00);
    tick(1);
    tick(4 * Div);
    checks++;
    if ({txd, tsre} !== 2'b00) begin
      failures++;
      $display("FAIL pre_reset_bit3: got txd,tsre=%b expected 00", {txd, tsre});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({txd, tsre, tbre} !== 3'b111) begin
      failures++;
      $display("FAIL async_reset: got txd,tsre,tbre=%b expected 111", {txd, tsre, tbre});
    end
    tick(2);
    rst = 1'b0;
    tick(8);
    checks++;
    if ({txd, tsre} !== 2'b11) begin
      failures++;
      $display("FAIL post_reset_idle: got txd,tsre=%b expected 11", {txd, tsre});
    end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    bit seen;
    seen = 1'b0;
    write_byte(8'h7E);
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      if (data_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL loopback_timeout: got data_ready=%b expected 1", data_ready);
    end
    rdn = 1'b0;
    #1;
    checks++;
    if (data !== 16'h007E) begin
      failures++;
      $display("FAIL loopback_read: got %h expected 007e", data);
    end
    rdn = 1'b1;
    tick(4);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
`ifndef UART_LOOPBACK_EN
    test_rx_read();
    test_overrun_frame_err();
`endif
    test_reset_mid_tx();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
